// File: rtl/mem_dump_pkg.sv
// Shared defaults and FSM encodings for the memory dump streamer.
// The CHK state exists only when MEM_DUMP_CHKSUM_EN is defined.
package mem_dump_pkg;

    localparam int WORD_SIZE_DEF = 8;
    localparam int ADDR_SIZE_DEF = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        SEND = 3'd3,
`ifdef MEM_DUMP_CHKSUM_EN
        CHK  = 3'd4,
`endif
        FIN  = 3'd5
    } state_t;

    // States in which the engine counts as busy (FIN is excluded on purpose).
    function automatic logic state_busy(input state_t s);
        return (s != IDLE) && (s != FIN);
    endfunction

endpackage

// File: rtl/mem_dump_if.sv
// Control, memory read port and output stream of the memory dump streamer.
// master = the dump engine, slave = the surrounding system (memory + consumer).
interface mem_dump_if import mem_dump_pkg::*; #(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
);
    logic                 start;
    logic [ADDR_SIZE-1:0] start_addr;
    logic [ADDR_SIZE-1:0] end_addr;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 mem_rd;
    logic [WORD_SIZE-1:0] mem_data;
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, start_addr, end_addr, mem_data, out_ready,
        output mem_addr, mem_rd, out_data, out_valid, busy, done
    );

    modport slave (
        output start, start_addr, end_addr, mem_data, out_ready,
        input  mem_addr, mem_rd, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/mem_dump.sv
// Streams memory[start_addr..end_addr] (wrapping) out over a valid/ready port, 3 cycles per byte.
// Define MEM_DUMP_CHKSUM_EN to append a byte that makes the stream sum to zero.
module mem_dump import mem_dump_pkg::*; #(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic      clk,
    input  logic      rst,
    mem_dump_if.master bus
);

    state_t               state_reg, state_next;
    logic [ADDR_SIZE-1:0] addr_reg;
    logic [ADDR_SIZE-1:0] last_reg;
    logic [WORD_SIZE-1:0] out_data_reg;
`ifdef MEM_DUMP_CHKSUM_EN
    logic [WORD_SIZE-1:0] checksum_reg;
`endif

    logic xfer;
    logic at_last;

    assign xfer    = bus.out_valid && bus.out_ready;
    assign at_last = (addr_reg == last_reg);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            last_reg     <= '0;
            out_data_reg <= '0;
`ifdef MEM_DUMP_CHKSUM_EN
            checksum_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            unique case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        addr_reg     <= bus.start_addr;
                        last_reg     <= bus.end_addr;
`ifdef MEM_DUMP_CHKSUM_EN
                        checksum_reg <= '0;
`endif
                    end
                end
                CAPT: begin
                    out_data_reg <= bus.mem_data;
`ifdef MEM_DUMP_CHKSUM_EN
                    checksum_reg <= checksum_reg + bus.mem_data;
`endif
                end
                SEND: begin
                    if (xfer) begin
                        if (at_last) begin
`ifdef MEM_DUMP_CHKSUM_EN
                            // The checksum already includes the last byte here.
                            out_data_reg <= '0 - checksum_reg;
`endif
                        end else begin
                            // Natural width overflow gives the required wrap to 0.
                            addr_reg <= addr_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (bus.start) state_next = READ;
            READ: state_next = CAPT;
            CAPT: state_next = SEND;
            SEND: begin
                if (xfer) begin
                    if (at_last) begin
`ifdef MEM_DUMP_CHKSUM_EN
                        state_next = CHK;
`else
                        state_next = FIN;
`endif
                    end else begin
                        state_next = READ;
                    end
                end
            end
`ifdef MEM_DUMP_CHKSUM_EN
            CHK: if (xfer) state_next = FIN;
`endif
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_addr = addr_reg;
    assign bus.mem_rd   = (state_reg == READ);
    assign bus.out_data = out_data_reg;
`ifdef MEM_DUMP_CHKSUM_EN
    assign bus.out_valid = (state_reg == SEND) || (state_reg == CHK);
`else
    assign bus.out_valid = (state_reg == SEND);
`endif
    assign bus.busy = state_busy(state_reg);
    assign bus.done = (state_reg == FIN);

endmodule

// File: doc/mem_dump.md
MEM_DUMP -- requirements
Module: mem_dump

Interface
- REQ-001 Parameter WORD_SIZE, default 8: data byte width.
- REQ-002 Parameter ADDR_SIZE, default 8: memory address width (256 locations).
- REQ-003 clk  input  1  single system clock; all state updates on rising edge.
- REQ-004 rst  input  1  reset, synchronous and active-low.
- REQ-005 start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
- REQ-006 start_addr  input  ADDR_SIZE  first address to dump; sampled with start.
- REQ-007 end_addr  input  ADDR_SIZE  last address to dump, inclusive; sampled with start.
- REQ-008 mem_addr  output  ADDR_SIZE  read address to processor memory.
- REQ-009 mem_rd  output  1  read strobe; memory returns mem_data exactly one cycle later.
- REQ-010 mem_data  input  WORD_SIZE  read data from memory.
- REQ-011 out_data  output  WORD_SIZE  streamed byte.
- REQ-012 out_valid  output  1  out_data valid.
- REQ-013 out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high at a clock edge.
- REQ-014 busy  output  1  high from the cycle after an accepted start until done.
- REQ-015 done  output  1  one-cycle pulse after the final byte transfers.

Function
- REQ-016 The FSM SHALL have states IDLE, READ, CAPT, SEND, CHK, FIN.
- REQ-017 IDLE: start=1 SHALL latch start_addr into addr and end_addr into last, clear the checksum, and go to READ.
- REQ-018 READ: mem_rd=1 and mem_addr=addr for exactly one cycle, then go to CAPT.
- REQ-019 CAPT: mem_data SHALL be registered into out_data, added to the checksum modulo 2^WORD_SIZE, and the FSM SHALL go to SEND.
- REQ-020 SEND: out_valid=1 with out_data held stable until out_ready=1; on transfer, if addr==last go to CHK (macro defined) or FIN, else addr <= addr+1 and go to READ.
- REQ-021 Address increment SHALL wrap 2^ADDR_SIZE-1 -> 0; end_addr < start_addr dumps through the wrap (e.g. 254,255,0,1).
- REQ-022 start_addr==end_addr SHALL dump exactly one byte.
- REQ-023 FIN: done=1 for one cycle, busy=0 in that cycle, then return to IDLE.
- REQ-024 start SHALL be ignored while busy; start in the FIN cycle SHALL be ignored.
- REQ-025 The minimum time SHALL be 3 cycles per byte (READ, CAPT, SEND with out_ready already high).
- REQ-026 mem_rd SHALL be 0 in every state except READ; mem_addr SHALL hold addr at all times.

Reset
- REQ-027 rst=0 at a clock edge SHALL force IDLE, with out_valid=0, mem_rd=0, busy=0, done=0, out_data=0, mem_addr=0, and checksum=0.
- REQ-028 Reset mid-dump SHALL abort with no further bytes or done pulse; an unaccepted out_valid SHALL be dropped.

Configuration
- REQ-029 With MEM_DUMP_CHKSUM_EN defined: after the last data byte, CHK SHALL present out_data = two's-complement negation of the checksum (the stream plus this byte sums to 0 mod 256) using the same valid/ready rule, then go to FIN.
- REQ-030 Without MEM_DUMP_CHKSUM_EN: no CHK state, no checksum register; SEND goes directly to FIN.

Structure
- REQ-031 WORD_SIZE, ADDR_SIZE defaults and the FSM state encodings SHALL live in the shared risc_defs include, used by both top and mem_dump.
- REQ-032 The block SHALL be a single module with no sub-modules, instantiated beside Memory in top with its read port muxed onto the memory address while the processor is held in reset.

Verification
- REQ-033 Memory[128..131]=10,20,30,40, start 128..131, out_ready=1 -> bytes 10,20,30,40 one per 3 cycles, done 1 cycle after the last transfer.
- REQ-034 Same range with MEM_DUMP_CHKSUM_EN -> 10,20,30,40 then 156 (0x9C); sum mod 256 = 0.
- REQ-035 Memory[255]=7, [0]=0, start 255..0 -> bytes 7,0; mem_addr sequence 255,0.
- REQ-036 out_ready held low 5 cycles during the first byte -> out_valid high and out_data stable for the whole stall, no further mem_rd until the transfer.
- REQ-037 start re-pulsed while busy -> ignored, byte count unchanged; rst=0 during the second byte -> out_valid=0 and busy=0 next cycle, no done.
- REQ-038 start_addr=end_addr=139 with memory[139]=0 -> exactly one byte 0, then done.
